// File: rtl/cursor_ctrl.sv
// Cursor controller: four active-low buttons move an (x, y) cursor on a
// MAX_X x MAX_Y grid. A press event steps the cursor once. A steady hold
// then auto-repeats, first after REPEAT_DELAY cycles and then every
// REPEAT_RATE cycles. Edges either wrap or clamp, depending on WRAP.
module cursor_ctrl #(
  parameter int MAX_X        = 64,
  parameter int MAX_Y        = 48,
  parameter int CW           = 8,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    move,
  output logic [CW-1:0] cursor_x,
  output logic [CW-1:0] cursor_y,
  output logic          start_screen,
  output logic          step
);

  // The counter must hold the larger of the two reload values.
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_t;

  // Button synchronizer. Buttons are active low, so "all released" is 4'hF.
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;

  // Pressed set as seen by the logic, and its value from the previous cycle.
  logic [3:0] pressed;
  logic [3:0] p_prev_reg;

  state_t         state_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Index 0 is the column and index 1 is the row.
  logic [CW-1:0] coord_reg  [2];
  logic [CW-1:0] coord_next [2];

  logic step_reg;
  logic start_reg;

  logic press_evt;
  logic take_step;

  assign pressed = ~sync2_reg;

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 4'hF;
      sync2_reg <= 4'hF;
    end else begin
      sync1_reg <= move;
      sync2_reg <= sync1_reg;
    end
  end

  // A press event is any change in a non-empty pressed set.
  // This includes adding or removing one key while others stay held.
  // A step happens on a press event. While the held set is unchanged, a step
  // also happens when the repeat counter expires in DELAY or REPEAT.
  always_comb begin
    press_evt = (pressed != 4'b0000) && (pressed != p_prev_reg);
    take_step = press_evt ||
                ((pressed != 4'b0000) && (state_reg != ST_IDLE) && (cnt_reg == '0));
  end

  // Per-axis next coordinate for a step.
  // Opposing keys cancel out. Each axis then either wraps or clamps at its
  // ends. The edges are compared before any add or subtract, so the CW-bit
  // arithmetic can never overflow.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam int            AXIS_MAX = (gi == 0) ? MAX_X : MAX_Y;
      localparam logic [CW-1:0] LAST     = CW'(AXIS_MAX - 1);

      logic inc;
      logic dec;

      // Column: right (bit 3) increments and left (bit 0) decrements.
      // Row: down (bit 1) increments and up (bit 2) decrements.
      assign inc = (gi == 0) ? pressed[3] : pressed[1];
      assign dec = (gi == 0) ? pressed[0] : pressed[2];

      assign coord_next[gi] =
          (inc && !dec) ? ((coord_reg[gi] == LAST) ? ((WRAP != 0) ? '0 : LAST)
                                                   : coord_reg[gi] + 1'b1) :
          (dec && !inc) ? ((coord_reg[gi] == '0)   ? ((WRAP != 0) ? LAST : '0)
                                                   : coord_reg[gi] - 1'b1) :
                          coord_reg[gi];
    end
  endgenerate

  // Repeat FSM together with the registered cursor, step and start_screen outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      p_prev_reg   <= 4'b0000;
      coord_reg[0] <= '0;
      coord_reg[1] <= '0;
      step_reg     <= 1'b0;
      start_reg    <= 1'b1;
    end else begin
      p_prev_reg <= pressed;
      step_reg   <= take_step;

      if (take_step) begin
        coord_reg[0] <= coord_next[0];
        coord_reg[1] <= coord_next[1];
        start_reg    <= 1'b0;
      end

      if (pressed == 4'b0000) begin
        // Everything released: abandon any hold without stepping.
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
      end else if (press_evt) begin
        // A new press (or a change to the held set) restarts the hold delay.
        if (REPEAT_DELAY > 0) begin
          state_reg <= ST_DELAY;
          cnt_reg   <= DELAY_LOAD;
        end else begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      end else begin
        case (state_reg)
          ST_DELAY: begin
            if (cnt_reg == '0) begin
              state_reg <= ST_REPEAT;
              cnt_reg   <= RATE_LOAD;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          ST_REPEAT: begin
            if (cnt_reg == '0) begin
              cnt_reg <= RATE_LOAD;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end
        endcase
      end
    end
  end

  assign cursor_x     = coord_reg[0];
  assign cursor_y     = coord_reg[1];
  assign step         = step_reg;
  assign start_screen = start_reg;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Testbench for cursor_ctrl. It drives a wrapping instance and a clamping
// instance with the same buttons. A hold-age model predicts the outputs of
// both instances on every cycle. Hand-computed checkpoints pin the scenarios.
module tb_cursor_ctrl;

  localparam int MX = 8;
  localparam int MY = 6;
  localparam int RD = 4;
  localparam int RR = 2;

  logic       clk;
  logic       rst;
  logic [3:0] move;

  logic [3:0] w_x, w_y, c_x, c_y;
  logic       w_start, w_step, c_start, c_step;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  cursor_ctrl #(.MAX_X(MX), .MAX_Y(MY), .CW(4), .WRAP(1),
                .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_w (
    .clk(clk), .rst(rst), .move(move),
    .cursor_x(w_x), .cursor_y(w_y), .start_screen(w_start), .step(w_step)
  );

  cursor_ctrl #(.MAX_X(MX), .MAX_Y(MY), .CW(4), .WRAP(0),
                .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_c (
    .clk(clk), .rst(rst), .move(move),
    .cursor_x(c_x), .cursor_y(c_y), .start_screen(c_start), .step(c_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pressed sets reach the logic two cycles late. A step is due when the set
  // changes, or when a steady non-empty set has been held for RD + k*RR cycles.
  logic [3:0] d1 = 4'b0, d2 = 4'b0, pp = 4'b0, pe;
  int  age = 0;
  bit  st;
  int  m_x [2] = '{0, 0};
  int  m_y [2] = '{0, 0};
  bit  m_step = 0;
  bit  m_start = 1;
  int  dx, dy;

  function automatic int move_axis(input int v, input int d, input int mx, input bit wrap);
    int n;
    n = v + d;
    if (n < 0) n = wrap ? mx - 1 : 0;
    else if (n >= mx) n = wrap ? 0 : mx - 1;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1 = 4'b0; d2 = 4'b0; pp = 4'b0; age = 0;
      m_x[0] = 0; m_x[1] = 0; m_y[0] = 0; m_y[1] = 0;
      m_step = 0; m_start = 1;
    end else begin
      pe = d2;
      st = 0;
      if (pe == 4'b0) begin
        age = 0;
      end else if (pe != pp) begin
        st = 1;
        age = 0;
      end else begin
        age++;
        if (RD > 0 && age >= RD && ((age - RD) % RR) == 0) st = 1;
      end
      if (st) begin
        dx = int'(pe[3]) - int'(pe[0]);
        dy = int'(pe[1]) - int'(pe[2]);
        m_x[0] = move_axis(m_x[0], dx, MX, 1'b1);
        m_y[0] = move_axis(m_y[0], dy, MY, 1'b1);
        m_x[1] = move_axis(m_x[1], dx, MX, 1'b0);
        m_y[1] = move_axis(m_y[1], dy, MY, 1'b0);
        m_start = 0;
      end
      m_step = st;
      pp = pe;
      d2 = d1;
      d1 = ~move;
    end
  end

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("w_x", w_x, m_x[0]);
      check("w_y", w_y, m_y[0]);
      check("w_step", w_step, m_step);
      check("w_start", w_start, m_start);
      check("c_x", c_x, m_x[1]);
      check("c_y", c_y, m_y[1]);
      check("c_step", c_step, m_step);
      check("c_start", c_start, m_start);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  logic [19:0] mask;
  int          cnt;

  initial begin
    move = 4'hF;
    rst  = 1'b1;
    #3 rst = 1'b0;
    chk_en = 1;
    wait_n(3);
    check("rst_w_x", w_x, 0);
    check("rst_w_y", w_y, 0);
    check("rst_w_start", w_start, 1);
    check("rst_w_step", w_step, 0);
    rst = 1'b1;
    wait_n(3);

    // Single-cycle left pulse: wraps to 7, or clamps at 0.
    move = 4'b1110; wait_n(1); move = 4'hF; wait_n(2);
    check("r19_w_x", w_x, 7);
    check("r19_w_step", w_step, 1);
    check("r19_w_start", w_start, 0);
    check("r19_w_y", w_y, 0);
    check("r19_c_x", c_x, 0);
    wait_n(1);
    check("r19_w_step_once", w_step, 0);
    wait_n(3);

    // Bring the wrapping instance to x=0, then hold right for 12 cycles.
    move = 4'b0111; wait_n(1); move = 4'hF; wait_n(6);
    move = 4'b0111;
    mask = '0;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      if (j == 12) move = 4'hF;
      if (j >= 3 && w_step) mask[j-3] = 1'b1;
    end
    check("r20_step_mask", mask, 20'h00551);
    check("r20_w_x", w_x, 5);
    check("r20_c_x", c_x, 6);
    wait_n(3);

    // Clamp at the right edge while holding right.
    move = 4'b0111; wait_n(1); move = 4'hF; wait_n(6);
    move = 4'b0111;
    cnt = 0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j == 8) move = 4'hF;
      if (c_step) cnt++;
    end
    check("r21_c_steps", cnt, 3);
    check("r21_c_x", c_x, 7);
    check("r21_w_x", w_x, 1);
    wait_n(3);
    move = 4'b1011; wait_n(1); move = 4'hF; wait_n(2);
    check("r21_c_y", c_y, 0);
    check("r21_w_y", w_y, 5);
    wait_n(4);

    // Left and right together: a net-zero step. Then a diagonal step.
    move = 4'b0110; wait_n(1); move = 4'hF; wait_n(2);
    check("r22_w_step", w_step, 1);
    check("r22_w_x", w_x, 1);
    wait_n(4);
    move = 4'b0101; wait_n(1); move = 4'hF; wait_n(2);
    check("r22_w_x_diag", w_x, 2);
    check("r22_w_y_diag", w_y, 0);
    check("r22_c_x_diag", c_x, 7);
    check("r22_c_y_diag", c_y, 1);
    wait_n(4);

    // Hold down, then add right at hold cycle 2.
    move = 4'b1101; wait_n(2); move = 4'b0101;
    mask = '0;
    for (int j = 3; j <= 14; j++) begin
      @(negedge clk);
      if (j == 10) move = 4'hF;
      if (w_step) mask[j-3] = 1'b1;
    end
    check("r23_step_mask", mask, 20'h00145);
    check("r23_w_x", w_x, 5);
    check("r23_w_y", w_y, 4);
    check("r23_c_y", c_y, 5);
    wait_n(4);

    // Reset during REPEAT with x=5, keeping up held through the reset release.
    move = 4'b1011; wait_n(10);
    check("r24_pre_w_x", w_x, 5);
    check("r24_pre_w_y", w_y, 1);
    #2 rst = 1'b0;
    #1;
    check("r24_async_w_x", w_x, 0);
    check("r24_async_w_y", w_y, 0);
    check("r24_async_w_start", w_start, 1);
    check("r24_async_w_step", w_step, 0);
    check("r24_async_c_y", c_y, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_n(2);
    check("r24_no_early_step", w_step, 0);
    wait_n(1);
    check("r24_w_step", w_step, 1);
    check("r24_w_y", w_y, 5);
    check("r24_c_step", c_step, 1);
    check("r24_c_y", c_y, 0);
    move = 4'hF;
    wait_n(4);
    check("r24_w_start", w_start, 0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
